// File: rtl/if_branch_stash.sv
// In-flight conditional branch stash between IF and EX: trains the BHT and issues mispredict redirects.
// Optional performance counters are enabled by defining IF_BRANCH_STASH_PERF_EN.
module if_branch_stash #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_branch_valid,
  input  logic [31:0] IF_pc,
  input  logic [31:0] IF_target,
  input  logic        IF_prediction_take,
  input  logic        EX_resolve,
  input  logic        EX_take,
  output logic        pc_jmp_feedback,
  output logic        pc_jmp_take,
  output logic [31:0] pc_stash_base,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        stash_full,
  output logic        stash_empty
`ifdef IF_BRANCH_STASH_PERF_EN
  ,
  output logic [31:0] perf_resolved,
  output logic [31:0] perf_mispredict
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      pc_mem  [DEPTH];
  logic [31:0]      tgt_mem [DEPTH];
  logic [DEPTH-1:0] pred_mem;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic        pop;
  logic        mispredict;
  logic        push_ok;
  logic [31:0] head_pc;
  logic [31:0] head_tgt;
  logic        head_pred;

  always_comb begin
    head_pc    = pc_mem[head];
    head_tgt   = tgt_mem[head];
    head_pred  = pred_mem[head];
    pop        = EX_resolve && (count != '0);
    mispredict = pop && (EX_take != head_pred);
    // A correct pop frees a slot this cycle, so a push is accepted even when full;
    // a mispredict flushes everything younger, including this cycle's push.
    push_ok    = IF_branch_valid && !mispredict && ((count < DEPTH_C) || pop);
  end

  assign stash_full  = (count == DEPTH_C);
  assign stash_empty = (count == '0);

  // Entry storage is not reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      pc_mem[tail]   <= IF_pc;
      tgt_mem[tail]  <= IF_target;
      pred_mem[tail] <= IF_prediction_take;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      pc_jmp_feedback <= 1'b0;
      pc_jmp_take     <= 1'b0;
      pc_stash_base   <= '0;
      redirect        <= 1'b0;
      redirect_pc     <= '0;
    end else begin
      pc_jmp_feedback <= pop;
      redirect        <= mispredict;
      if (pop) begin
        pc_jmp_take   <= EX_take;
        pc_stash_base <= head_pc;
      end
      if (mispredict) begin
        redirect_pc <= EX_take ? head_tgt : head_pc + 32'd4;
        head        <= tail;
        count       <= '0;
      end else begin
        if (pop)
          head <= head + PTR_W'(1);
        if (push_ok)
          tail <= tail + PTR_W'(1);
        case ({push_ok, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef IF_BRANCH_STASH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_resolved   <= '0;
      perf_mispredict <= '0;
    end else begin
      if (pop)
        perf_resolved <= perf_resolved + 32'd1;
      if (mispredict)
        perf_mispredict <= perf_mispredict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_branch_stash.sv
// Directed table-driven bench for if_branch_stash (DEPTH=4) plus hand-written flush sequences.
module tb_if_branch_stash;

  logic        clk = 1'b0;
  logic        reset;
  logic        IF_branch_valid;
  logic [31:0] IF_pc;
  logic [31:0] IF_target;
  logic        IF_prediction_take;
  logic        EX_resolve;
  logic        EX_take;
  logic        pc_jmp_feedback;
  logic        pc_jmp_take;
  logic [31:0] pc_stash_base;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stash_full;
  logic        stash_empty;
`ifdef IF_BRANCH_STASH_PERF_EN
  logic [31:0] perf_resolved;
  logic [31:0] perf_mispredict;
`endif

  if_branch_stash #(.DEPTH(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .IF_branch_valid    (IF_branch_valid),
    .IF_pc              (IF_pc),
    .IF_target          (IF_target),
    .IF_prediction_take (IF_prediction_take),
    .EX_resolve         (EX_resolve),
    .EX_take            (EX_take),
    .pc_jmp_feedback    (pc_jmp_feedback),
    .pc_jmp_take        (pc_jmp_take),
    .pc_stash_base      (pc_stash_base),
    .redirect           (redirect),
    .redirect_pc        (redirect_pc),
    .stash_full         (stash_full),
    .stash_empty        (stash_empty)
`ifdef IF_BRANCH_STASH_PERF_EN
    ,
    .perf_resolved      (perf_resolved),
    .perf_mispredict    (perf_mispredict)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        bv;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
    logic        res;
    logic        take;
    logic        e_fb;
    logic        e_take;
    logic [31:0] e_base;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input string name, input logic rst, input logic bv, input logic [31:0] pc,
                     input logic [31:0] tgt, input logic pred, input logic res, input logic take,
                     input logic e_fb, input logic e_take, input logic [31:0] e_base,
                     input logic e_redir, input logic [31:0] e_rpc, input logic e_full,
                     input logic e_empty);
    vec_t v;
    v.name = name; v.rst = rst; v.bv = bv; v.pc = pc; v.tgt = tgt; v.pred = pred;
    v.res = res; v.take = take; v.e_fb = e_fb; v.e_take = e_take; v.e_base = e_base;
    v.e_redir = e_redir; v.e_rpc = e_rpc; v.e_full = e_full; v.e_empty = e_empty;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic bv, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred, input logic res, input logic take);
    reset = rst; IF_branch_valid = bv; IF_pc = pc; IF_target = tgt;
    IF_prediction_take = pred; EX_resolve = res; EX_take = take;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got fb/take/base/redir/rpc/full/empty=%h want %h", name, act, exp);
    end
  endtask

  function automatic logic [68:0] outs();
    return {pc_jmp_feedback, pc_jmp_take, pc_stash_base, redirect, redirect_pc, stash_full, stash_empty};
  endfunction

  initial begin
    //   name            rst bv pc            tgt          pr res tk   fb tk base          rd rpc          fu em
    add("reset",         1, 0, 32'h0,        32'h0,       0, 0, 0,   0, 0, 32'h0,        0, 32'h0,       0, 1);
    add("push100",       0, 1, 32'h100,      32'h80,      1, 0, 0,   0, 0, 32'h0,        0, 32'h0,       0, 0);
    add("pop_correct",   0, 0, 32'h0,        32'h0,       0, 1, 1,   1, 1, 32'h100,      0, 32'h0,       0, 1);
    add("fb_one_cycle",  0, 0, 32'h0,        32'h0,       0, 0, 0,   0, 1, 32'h100,      0, 32'h0,       0, 1);
    add("push200",       0, 1, 32'h200,      32'h300,     1, 0, 0,   0, 1, 32'h100,      0, 32'h0,       0, 0);
    add("push204",       0, 1, 32'h204,      32'h400,     1, 0, 0,   0, 1, 32'h100,      0, 32'h0,       0, 0);
    add("mispredict_nt", 0, 1, 32'h208,      32'h500,     1, 1, 0,   1, 0, 32'h200,      1, 32'h204,     0, 1);
    add("after_flush",   0, 0, 32'h0,        32'h0,       0, 0, 0,   0, 0, 32'h200,      0, 32'h204,     0, 1);
    add("resolve_empty", 0, 0, 32'h0,        32'h0,       0, 1, 1,   0, 0, 32'h200,      0, 32'h204,     0, 1);
    add("fill1",         0, 1, 32'h10,       32'h1010,    0, 0, 0,   0, 0, 32'h200,      0, 32'h204,     0, 0);
    add("fill2",         0, 1, 32'h20,       32'h1020,    0, 0, 0,   0, 0, 32'h200,      0, 32'h204,     0, 0);
    add("fill3",         0, 1, 32'h30,       32'h1030,    0, 0, 0,   0, 0, 32'h200,      0, 32'h204,     0, 0);
    add("fill4_full",    0, 1, 32'h40,       32'h1040,    0, 0, 0,   0, 0, 32'h200,      0, 32'h204,     1, 0);
    add("push_drop",     0, 1, 32'h50,       32'h1050,    0, 0, 0,   0, 0, 32'h200,      0, 32'h204,     1, 0);
    add("pop_push_full", 0, 1, 32'h60,       32'h1060,    0, 1, 0,   1, 0, 32'h10,       0, 32'h204,     1, 0);
    add("drain20",       0, 0, 32'h0,        32'h0,       0, 1, 0,   1, 0, 32'h20,       0, 32'h204,     0, 0);
    add("drain30",       0, 0, 32'h0,        32'h0,       0, 1, 0,   1, 0, 32'h30,       0, 32'h204,     0, 0);
    add("drain40",       0, 0, 32'h0,        32'h0,       0, 1, 0,   1, 0, 32'h40,       0, 32'h204,     0, 0);
    add("drain60",       0, 0, 32'h0,        32'h0,       0, 1, 0,   1, 0, 32'h60,       0, 32'h204,     0, 1);
    add("push_top_p0",   0, 1, 32'hFFFFFFFC, 32'h8,       0, 0, 0,   0, 0, 32'h60,       0, 32'h204,     0, 0);
    add("top_correct",   0, 0, 32'h0,        32'h0,       0, 1, 0,   1, 0, 32'hFFFFFFFC, 0, 32'h204,     0, 1);
    add("push_top_p1",   0, 1, 32'hFFFFFFFC, 32'h8,       1, 0, 0,   0, 0, 32'hFFFFFFFC, 0, 32'h204,     0, 0);
    add("top_wrap",      0, 0, 32'h0,        32'h0,       0, 1, 0,   1, 0, 32'hFFFFFFFC, 1, 32'h0,       0, 1);
    add("push500_p0",    0, 1, 32'h500,      32'h600,     0, 0, 0,   0, 0, 32'hFFFFFFFC, 0, 32'h0,       0, 0);
    add("mispredict_t",  0, 0, 32'h0,        32'h0,       0, 1, 1,   1, 1, 32'h500,      1, 32'h600,     0, 1);
    add("rfill1",        0, 1, 32'h700,      32'h800,     1, 0, 0,   0, 1, 32'h500,      0, 32'h600,     0, 0);
    add("rfill2",        0, 1, 32'h704,      32'h800,     1, 0, 0,   0, 1, 32'h500,      0, 32'h600,     0, 0);
    add("rfill3",        0, 1, 32'h708,      32'h800,     1, 0, 0,   0, 1, 32'h500,      0, 32'h600,     0, 0);
    add("reset_resolve", 1, 1, 32'h70C,      32'h800,     1, 1, 1,   0, 0, 32'h0,        0, 32'h0,       0, 1);
    add("post_reset",    0, 0, 32'h0,        32'h0,       0, 0, 0,   0, 0, 32'h0,        0, 32'h0,       0, 1);

    reset = 1'b1; IF_branch_valid = 1'b0; IF_pc = '0; IF_target = '0;
    IF_prediction_take = 1'b0; EX_resolve = 1'b0; EX_take = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].bv, vecs[i].pc, vecs[i].tgt, vecs[i].pred, vecs[i].res, vecs[i].take);
      check(vecs[i].name, outs(),
            {vecs[i].e_fb, vecs[i].e_take, vecs[i].e_base, vecs[i].e_redir, vecs[i].e_rpc,
             vecs[i].e_full, vecs[i].e_empty});
`ifdef IF_BRANCH_STASH_PERF_EN
      if (vecs[i].name == "post_reset") begin
        total++;
        if (perf_resolved !== 32'd0 || perf_mispredict !== 32'd0) begin
          bad++;
          $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_resolved, perf_mispredict);
        end
      end
`endif
    end

    // Flush from a full stash with a simultaneous push; stash must end up empty and stay quiet.
    for (int unsigned k = 0; k < 4; k++)
      drive(1'b0, 1'b1, 32'h900 + 32'(k * 4), 32'hA00, 1'b1, 1'b0, 1'b0);
    check("seq_full", outs(), {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0});
    drive(1'b0, 1'b1, 32'h910, 32'hA00, 1'b1, 1'b1, 1'b0);
    check("seq_flush_full", outs(), {1'b1, 1'b0, 32'h900, 1'b1, 32'h904, 1'b0, 1'b1});
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("seq_flush_quiet", outs(), {1'b0, 1'b0, 32'h900, 1'b0, 32'h904, 1'b0, 1'b1});

    // Wrapped pointers: push then pop in the same cycle on a one-entry stash keeps count at one.
    drive(1'b0, 1'b1, 32'hB00, 32'hC00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'hB04, 32'hC00, 1'b0, 1'b1, 1'b0);
    check("seq_pop_push", outs(), {1'b1, 1'b0, 32'hB00, 1'b0, 32'h904, 1'b0, 1'b0});
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("seq_pop_last", outs(), {1'b1, 1'b0, 32'hB04, 1'b0, 32'h904, 1'b0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_branch_stash.md
IF_BRANCH_STASH -- requirements
Module: IF_branch_stash

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight branch entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port IF_branch_valid  input  1  IF issues a predicted conditional branch this cycle (push).
REQ-005 SHALL have port IF_pc  input  32  PC of the pushed branch.
REQ-006 SHALL have port IF_target  input  32  taken target of the pushed branch.
REQ-007 SHALL have port IF_prediction_take  input  1  direction predicted by the branch history table for the pushed branch.
REQ-008 SHALL have port EX_resolve  input  1  EX resolves the oldest outstanding branch this cycle (pop).
REQ-009 SHALL have port EX_take  input  1  actual direction of the resolved branch.
REQ-010 SHALL have port pc_jmp_feedback  output  1  one-cycle training strobe to the branch history table.
REQ-011 SHALL have port pc_jmp_take  output  1  actual direction accompanying the strobe.
REQ-012 SHALL have port pc_stash_base  output  32  PC of the resolved branch accompanying the strobe.
REQ-013 SHALL have port redirect  output  1  one-cycle mispredict strobe to the IF next-PC mux.
REQ-014 SHALL have port redirect_pc  output  32  corrected fetch PC accompanying redirect.
REQ-015 SHALL have port stash_full  output  1  count == DEPTH; IF stalls branch issue.
REQ-016 SHALL have port stash_empty  output  1  count == 0.

Function
REQ-017 SHALL hold entries {pc, target, prediction} in a circular FIFO with head/tail pointers and a count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-018 Push SHALL write at tail when IF_branch_valid=1 and count<DEPTH; push while full SHALL be dropped with no state change.
REQ-019 Pop SHALL occur when EX_resolve=1 and count>0; EX_resolve while empty SHALL be ignored (no strobes).
REQ-020 On pop at edge N, pc_jmp_feedback SHALL be 1 for exactly the cycle after N, with pc_jmp_take=EX_take and pc_stash_base=head pc (all registered, latency 1).
REQ-021 Mispredict SHALL be EX_take != head prediction; then redirect=1 for the cycle after N, redirect_pc = EX_take ? head target : head pc + 4 (32-bit wrap).
REQ-022 On mispredict all entries SHALL be flushed at edge N (count=0, head=tail); a push in the same cycle is younger and SHALL be discarded.
REQ-023 Push and correct-prediction pop in the same cycle SHALL both take effect, count unchanged; when full, this simultaneous push SHALL be accepted.
REQ-024 When not strobing, pc_jmp_feedback and redirect SHALL be 0; pc_jmp_take, pc_stash_base, redirect_pc hold last value.
REQ-025 stash_full and stash_empty SHALL be combinational from count.

Reset
REQ-026 While reset=1 at a rising edge: count=0, head=tail=0, pc_jmp_feedback=0, pc_jmp_take=0, pc_stash_base=0, redirect=0, redirect_pc=0; entry storage need not be cleared.
REQ-027 Reset SHALL take priority over simultaneous push/pop; a resolve in the reset cycle produces no strobe afterwards.

Configuration
REQ-028 With macro IF_BRANCH_STASH_PERF_EN defined, SHALL add outputs perf_resolved[31:0] and perf_mispredict[31:0], incremented on every pop and every mispredict, wrapping at 2^32, cleared by reset.
REQ-029 Without IF_BRANCH_STASH_PERF_EN the counters and ports SHALL not exist; all other behaviour identical.

Verification
REQ-030 Push pc=0x100 tgt=0x80 pred=1; resolve take=1 -> next cycle feedback=1, take=1, base=0x100, redirect=0, empty=1.
REQ-031 Push pc=0x200 tgt=0x300 pred=1, then pc=0x204; resolve take=0 -> redirect=1, redirect_pc=0x204, count=0, second entry gone.
REQ-032 Push 4 entries (DEPTH=4), push 5th -> full=1, 5th dropped; then pop+push same cycle, correct -> full stays 1, oldest order preserved.
REQ-033 Resolve on empty -> no feedback/redirect; pc=0xFFFFFFFC pred=0, take=0 is correct; pred=1 take=0 -> redirect_pc=0x00000000.
REQ-034 Fill 3 entries, assert reset with EX_resolve=1 -> next cycle all outputs 0, empty=1; perf counters (macro on) = 0.
